// File: rtl/spike_event_fifo.sv
// Timestamps spike events from the neuron core and queues them for a
// stallable raster/readout consumer over a valid/ready handshake.
module spike_event_fifo #(
  parameter int unsigned N     = 20,
  parameter int unsigned Q     = 8,
  parameter int unsigned TW    = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  input  logic          is_spiking,
  input  logic [N-1:0]  last_dv,
  input  logic          clear,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [TW-1:0] out_time,
  output logic [N-1:0]  out_dv,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [7:0]    dropped
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // last_dv is carried verbatim; Q only documents the fixed-point format
  if (Q > N) begin : g_q_exceeds_width
  end

  logic [TW+N-1:0] mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [TW-1:0]   ts;
  logic [TW+N-1:0] head;
  logic            full;
  logic            empty;
  logic            push_req;
  logic            pop;
  logic            push;
  logic            drop;

  always_comb begin
    full      = (count == FULL_CNT);
    empty     = (count == '0);
    out_valid = !empty;
    push_req  = step & is_spiking;
    pop       = out_valid & out_ready & !clear;
    // a pop in the same cycle frees the slot a full FIFO needs
    push      = push_req & !clear & (!full | pop);
    drop      = push_req & !clear & full & !pop;
    head      = mem[rd_ptr];
    out_time  = empty ? '0 : head[TW+N-1:N];
    out_dv    = empty ? '0 : head[N-1:0];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {ts, last_dv};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts       <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      dropped  <= '0;
    end else if (clear) begin
      ts       <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      dropped  <= '0;
    end else begin
      if (step) ts <= ts + TW'(1);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (dropped != 8'hFF) dropped <= dropped + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_spike_event_fifo.sv
// Directed self-checking bench for spike_event_fifo.
module tb_spike_event_fifo;

  localparam int unsigned N  = 20;
  localparam int unsigned TW = 16;
  localparam int unsigned AW = 3;

  logic          clk;
  logic          rst;
  logic          step;
  logic          is_spiking;
  logic [N-1:0]  last_dv;
  logic          clear;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_time;
  logic [N-1:0]  out_dv;
  logic [AW:0]   count;
  logic          overflow;
  logic [7:0]    dropped;

  int total;
  int bad;

  spike_event_fifo #(.N(20), .Q(8), .TW(16), .DEPTH(8), .AW(3)) dut (
    .clk(clk), .rst(rst), .step(step), .is_spiking(is_spiking),
    .last_dv(last_dv), .clear(clear), .out_valid(out_valid),
    .out_ready(out_ready), .out_time(out_time), .out_dv(out_dv),
    .count(count), .overflow(overflow), .dropped(dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic sp, input int dv, input logic rdy);
    step       = s;
    is_spiking = sp;
    last_dv    = dv[N-1:0];
    out_ready  = rdy;
  endtask

  task automatic do_clear();
    drive(1'b0, 1'b0, 0, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    clear = 1'b0;
    drive(1'b0, 1'b0, 0, 1'b0);

    #12;
    chk("rst valid", 32'(out_valid), 0);
    chk("rst count", 32'(count), 0);
    chk("rst time", 32'(out_time), 0);
    chk("rst dv", 32'(out_dv), 0);
    chk("rst overflow", 32'(overflow), 0);
    chk("rst dropped", 32'(dropped), 0);
    tick();
    rst = 1'b1;

    // two spikes on step indices 1 and 3, consumer always ready
    drive(1'b1, 1'b0, 0, 1'b1); tick();
    chk("t1 idle valid", 32'(out_valid), 0);
    drive(1'b1, 1'b1, 'h00A00, 1'b1); tick();
    chk("t1 ev1 valid", 32'(out_valid), 1);
    chk("t1 ev1 time", 32'(out_time), 1);
    chk("t1 ev1 dv", 32'(out_dv), 'h00A00);
    chk("t1 ev1 count", 32'(count), 1);
    drive(1'b1, 1'b0, 0, 1'b1); tick();
    chk("t1 popped valid", 32'(out_valid), 0);
    drive(1'b1, 1'b1, 'hFF600, 1'b1); tick();
    chk("t1 ev2 time", 32'(out_time), 3);
    chk("t1 ev2 dv", 32'(out_dv), 'hFF600);
    drive(1'b1, 1'b0, 0, 1'b1); tick();
    chk("t1 end count", 32'(count), 0);
    chk("t1 end time zero", 32'(out_time), 0);

    // ten spikes into a stalled consumer: two are dropped
    do_clear();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, i, 1'b0); tick();
    end
    drive(1'b0, 1'b0, 0, 1'b0);
    chk("t2 count", 32'(count), 8);
    chk("t2 overflow", 32'(overflow), 1);
    chk("t2 dropped", 32'(dropped), 2);
    tick();
    chk("t2 stall head time", 32'(out_time), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t2 drain time", 32'(out_time), 32'(i));
      chk("t2 drain dv", 32'(out_dv), 32'(i));
      tick();
    end
    chk("t2 drained count", 32'(count), 0);
    chk("t2 drained valid", 32'(out_valid), 0);
    chk("t2 overflow sticky", 32'(overflow), 1);

    // full with simultaneous pop and push
    do_clear();
    chk("t3 clear overflow", 32'(overflow), 0);
    chk("t3 clear dropped", 32'(dropped), 0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 'h100 + i, 1'b0); tick();
    end
    chk("t3 full count", 32'(count), 8);
    drive(1'b1, 1'b1, 'h12345, 1'b1); tick();
    chk("t3 pp count", 32'(count), 8);
    chk("t3 pp overflow", 32'(overflow), 0);
    chk("t3 pp head time", 32'(out_time), 1);
    drive(1'b0, 1'b0, 0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      chk("t3 drain time", 32'(out_time), 32'(i));
      chk("t3 drain dv", 32'(out_dv), (i < 8) ? 32'('h100 + i) : 32'h12345);
      tick();
    end
    chk("t3 drained count", 32'(count), 0);

    // timestamp wrap
    do_clear();
    for (int i = 0; i < 65535; i++) begin
      drive(1'b1, 1'b0, 0, 1'b0); tick();
    end
    drive(1'b1, 1'b1, 'h00001, 1'b0); tick();
    drive(1'b1, 1'b1, 'h00002, 1'b0); tick();
    drive(1'b0, 1'b0, 0, 1'b0);
    chk("t4 count", 32'(count), 2);
    chk("t4 time max", 32'(out_time), 'hFFFF);
    chk("t4 dv1", 32'(out_dv), 'h00001);
    out_ready = 1'b1; tick();
    chk("t4 time wrap", 32'(out_time), 0);
    chk("t4 dv2", 32'(out_dv), 'h00002);
    tick();
    chk("t4 drained", 32'(count), 0);
    out_ready = 1'b0;

    // clear beats a simultaneous spiking step
    do_clear();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 'h50 + i, 1'b0); tick();
    end
    chk("t5 queued", 32'(count), 3);
    drive(1'b1, 1'b1, 'h00777, 1'b0);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("t5 clr count", 32'(count), 0);
    chk("t5 clr valid", 32'(out_valid), 0);
    chk("t5 clr dropped", 32'(dropped), 0);
    drive(1'b1, 1'b1, 'h00888, 1'b0); tick();
    drive(1'b0, 1'b0, 0, 1'b0);
    chk("t5 restamp time", 32'(out_time), 0);
    chk("t5 restamp dv", 32'(out_dv), 'h00888);

    // asynchronous reset mid-drain
    do_clear();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b1, i, 1'b0); tick();
    end
    chk("t6 overflow set", 32'(overflow), 1);
    drive(1'b0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    drive(1'b0, 1'b0, 0, 1'b0);
    chk("t6 count before rst", 32'(count), 4);
    #2 rst = 1'b0;
    #1;
    chk("t6 async valid", 32'(out_valid), 0);
    chk("t6 async count", 32'(count), 0);
    chk("t6 async overflow", 32'(overflow), 0);
    chk("t6 async time", 32'(out_time), 0);
    tick();
    tick();
    rst = 1'b1;

    // dropped saturates at 255
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1'b1, i, 1'b0); tick();
    end
    drive(1'b0, 1'b0, 0, 1'b0);
    chk("t7 dropped sat", 32'(dropped), 255);
    chk("t7 count", 32'(count), 8);
    chk("t7 head time", 32'(out_time), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
